// File: rtl/mc_sequencer.sv
// mc_sequencer
// ------------
// Multi-cycle control FSM for a 16-bit, 4-register MIPS-subset datapath
// (shared ALU, register file, single unified memory). Sequences
// fetch / decode / execute / memory / write-back for
// add, sub, and, or, slt, addi, lw, sw and beq, drives every datapath
// select and write enable, and traps on illegal opcodes or on a memory
// access that stalls for MEM_TIMEOUT cycles.
//
// Memory handshake: mem_req is held high for as long as an access is
// pending; the access completes in the cycle where mem_ready is sampled
// high together with mem_req. mem_we is only meaningful while mem_req=1.
// mem_ready outside a request is ignored.
//
// Ports:
//   clock, reset_n          clock; asynchronous active-low reset
//   run                     start / keep fetching while high
//   opcode[3:0]             IR[15:12] of the latched instruction
//   zero                    ALU zero flag (beq)
//   mem_ready               memory completes the current access
//   mem_req, mem_we, iord   memory request, write strobe, address source
//   ir_write, pc_write      IR / PC load enables
//   pc_src[1:0]             PC source (00 ALU result, 01 ALUOut)
//   alu_src_a, alu_src_b    ALU operand selects
//   alu_ctl[2:0]            ALU operation
//   reg_write, reg_dst,
//   mem_to_reg              register-file write controls
//   instr_done              one-cycle retirement pulse
//   fault, fault_code[1:0]  sticky trap flag and cause (01 illegal, 10 timeout)
//   perf_instret[15:0]      retired-instruction counter
//   dbg_state[3:0]          current FSM state, for observation only
//
// Optional feature: define MC_PERF_COUNT_EN to build the retired-instruction
// counter; without it perf_instret is tied to zero.

module mc_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_ctl,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        instr_done,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [15:0] perf_instret,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_R     = 4'd8,
    S_WB_I     = 4'd9,
    S_WB_MEM   = 4'd10,
    S_BRANCH   = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e          state_q, state_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [1:0]      code_q, code_d;

  logic waiting;
  logic wd_expire;

  // A wait cycle is a request cycle without completion. The trap fires on
  // the wait cycle that brings the count to MEM_TIMEOUT; a cycle with
  // mem_ready is never a wait cycle, so a late completion always wins.
  assign waiting   = mem_req & ~mem_ready;
  assign wd_expire = waiting && (wd_q == TO_W'(MEM_TIMEOUT - 1));
  assign wd_d      = waiting ? wd_q + TO_W'(1) : '0;

  function automatic logic [2:0] r_alu_ctl(input logic [3:0] op);
    logic [2:0] ctl;
    case (op)
      4'b0000: ctl = ALU_ADD;
      4'b0001: ctl = ALU_SUB;
      4'b0010: ctl = ALU_AND;
      4'b0011: ctl = ALU_OR;
      4'b0111: ctl = ALU_SLT;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // State, watchdog and trap-cause registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      code_q  <= code_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wd_expire) begin
          state_d = S_TRAP;
          code_d  = FC_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: state_d = S_EXEC_R;
          4'b0100:                                     state_d = S_EXEC_I;
          4'b0101, 4'b0110:                            state_d = S_MEM_ADDR;
          4'b1000:                                     state_d = S_BRANCH;
          default: begin
            state_d = S_TRAP;
            code_d  = FC_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (opcode == 4'b0110) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (wd_expire) begin
          state_d = S_TRAP;
          code_d  = FC_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = run ? S_FETCH : S_IDLE;
        end else if (wd_expire) begin
          state_d = S_TRAP;
          code_d  = FC_TIMEOUT;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH: state_d = run ? S_FETCH : S_IDLE;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic: Moore per state, with IR/PC load and sw retirement
  // qualified by the memory completing in the same cycle.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctl    = 3'b000;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    fault      = 1'b0;
    fault_code = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_ctl   = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctl   = ALU_ADD;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_ctl   = r_alu_ctl(opcode);
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctl   = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctl    = ALU_SUB;
        pc_src     = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      S_TRAP: begin
        fault      = 1'b1;
        fault_code = code_q;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

`ifdef MC_PERF_COUNT_EN
  logic [15:0] instret_q, instret_d;

  // Free-running count of retirements; wraps naturally at 16 bits.
  assign instret_d = instr_done ? instret_q + 16'd1 : instret_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) instret_q <= 16'd0;
    else          instret_q <= instret_d;
  end

  assign perf_instret = instret_q;
`else
  assign perf_instret = 16'h0000;
`endif

endmodule
